// File: rtl/vga_word_display.sv
// Shows a 16-bit word as 16 vertical bars on a 640x480@60 VGA raster; new words swap in at vblank.
// Optional grid overlay: define VGA_WORD_DISPLAY_GRID_EN.
module vga_word_display #(
   parameter int          CLK_DIV  = 2,
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic [5:0]  FG_COLOR = 6'b001100,
   parameter logic [5:0]  BG_COLOR = 6'b000001
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] dout_in,
   input  logic        dout_valid,
   output logic        h_sync,
   output logic        v_sync,
   output logic        red0,
   output logic        red1,
   output logic        green0,
   output logic        green1,
   output logic        blue0,
   output logic        blue1,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 16;
   localparam int H_W     = $clog2(H_TOTAL + 1);
   localparam int V_W     = $clog2(V_TOTAL + 1);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BP_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [BP_W-1:0]  BP_LAST    = BP_W'(BAR_W - 1);
   localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0]   H_ACT      = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0]   HS_START   = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0]   HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0]   V_ACT      = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0]   V_ACT_LAST = V_W'(V_ACTIVE - 1);
   localparam logic [V_W-1:0]   VS_START   = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0]   VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [H_W-1:0]   h_q, h_d;
   logic [V_W-1:0]   v_q, v_d;
   logic [3:0]       bar_q, bar_d;
   logic [BP_W-1:0]  bar_px_q, bar_px_d;
   logic [15:0]      pend_q, pend_d;
   logic             pend_flag_q, pend_flag_d;
   logic [15:0]      disp_q, disp_d;
   logic             h_sync_q, h_sync_d;
   logic             v_sync_q, v_sync_d;
   logic [5:0]       color_q, color_d;
   logic             frame_start_q, frame_start_d;

   logic pix_en, h_wrap, v_wrap, xfer, active;

   assign pix_en = (div_q == DIV_LAST);
   assign h_wrap = (h_q == H_LAST);
   assign v_wrap = (v_q == V_LAST);
   assign active = (h_q < H_ACT) && (v_q < V_ACT);
   // Transfer fires on the pixel step that lands on the first blanking line.
   assign xfer   = pix_en && h_wrap && (v_q == V_ACT_LAST);

   always_comb begin
      div_d         = pix_en ? '0 : div_q + 1'b1;
      h_d           = h_q;
      v_d           = v_q;
      bar_d         = bar_q;
      bar_px_d      = bar_px_q;
      pend_d        = pend_q;
      pend_flag_d   = pend_flag_q;
      disp_d        = disp_q;
      h_sync_d      = h_sync_q;
      v_sync_d      = v_sync_q;
      color_d       = color_q;
      frame_start_d = 1'b0;

      if (pix_en) begin
         h_d = h_wrap ? '0 : h_q + 1'b1;
         if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 1'b1;
         end

         // Bar position tracked incrementally; bar saturates at 15 beyond the active area.
         if (h_wrap) begin
            bar_d    = '0;
            bar_px_d = '0;
         end else if (bar_px_q == BP_LAST) begin
            bar_px_d = '0;
            if (bar_q != 4'd15) begin
               bar_d = bar_q + 1'b1;
            end
         end else begin
            bar_px_d = bar_px_q + 1'b1;
         end

         h_sync_d = !((h_q >= HS_START) && (h_q < HS_END));
         v_sync_d = !((v_q >= VS_START) && (v_q < VS_END));

         color_d = '0;
         if (active) begin
            color_d = disp_q[~bar_q] ? FG_COLOR : BG_COLOR;
`ifdef VGA_WORD_DISPLAY_GRID_EN
            if ((bar_px_q == '0) || (v_q == '0) || (v_q == V_ACT_LAST)) begin
               color_d = 6'b111111;
            end
`endif
         end

         frame_start_d = h_wrap && v_wrap;
      end

      // A strobe on the transfer edge keeps the flag set so the new word follows a frame later.
      if (dout_valid) begin
         pend_d      = dout_in;
         pend_flag_d = 1'b1;
      end else if (xfer) begin
         pend_flag_d = 1'b0;
      end

      if (xfer && pend_flag_q) begin
         disp_d = pend_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         bar_q         <= '0;
         bar_px_q      <= '0;
         pend_q        <= '0;
         pend_flag_q   <= 1'b0;
         disp_q        <= '0;
         h_sync_q      <= 1'b1;
         v_sync_q      <= 1'b1;
         color_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         bar_q         <= bar_d;
         bar_px_q      <= bar_px_d;
         pend_q        <= pend_d;
         pend_flag_q   <= pend_flag_d;
         disp_q        <= disp_d;
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         color_q       <= color_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign h_sync      = h_sync_q;
   assign v_sync      = v_sync_q;
   assign frame_start = frame_start_q;
   assign {red1, red0, green1, green0, blue1, blue0} = color_q;

endmodule

// File: tb/tb_vga_word_display.sv
// Self-checking bench for vga_word_display on a shrunken raster (40x10 pixels, 2 clocks per pixel).
module tb_vga_word_display;

   localparam int CD    = 2;
   localparam int HA    = 32;
   localparam int HFP   = 2;
   localparam int HSW   = 3;
   localparam int HBP   = 3;
   localparam int VA    = 6;
   localparam int VFP   = 1;
   localparam int VSW   = 2;
   localparam int VBP   = 1;
   localparam int HT    = HA + HFP + HSW + HBP;
   localparam int VT    = VA + VFP + VSW + VBP;
   localparam int FRAME = HT * VT;
   localparam int TP    = VA * HT;
   localparam int HS0   = HA + HFP;
   localparam int HS1   = HA + HFP + HSW;
   localparam int VS0   = VA + VFP;
   localparam int VS1   = VA + VFP + VSW;
   localparam logic [5:0] FG = 6'b001100;
   localparam logic [5:0] BG = 6'b000001;
   localparam logic [8:0] RESET_VEC = 9'b110000000;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [15:0] dout_in = 16'h0;
   logic        dout_valid = 1'b0;
   logic        h_sync, v_sync, red0, red1, green0, green1, blue0, blue1, frame_start;
   logic [5:0]  color;
   logic [8:0]  dut_vec;
   logic        mon_en = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int e_cnt;

   typedef struct {
      int          e;
      logic [15:0] w;
   } strobe_t;
   strobe_t strobes[$];

   typedef struct {
      logic [15:0] word;
      int          h;
      int          v;
      logic [5:0]  exp;
   } vec_t;
   vec_t tbl[11];

   vga_word_display #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .FG_COLOR(FG), .BG_COLOR(BG)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .dout_in(dout_in), .dout_valid(dout_valid),
      .h_sync(h_sync), .v_sync(v_sync),
      .red0(red0), .red1(red1), .green0(green0), .green1(green1),
      .blue0(blue0), .blue1(blue1), .frame_start(frame_start)
   );

   assign color   = {red1, red0, green1, green0, blue1, blue0};
   assign dut_vec = {h_sync, v_sync, color, frame_start};

   always #5 clk_in = ~clk_in;

   // Edge counter since reset release, plus a timestamped log of every captured word.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         e_cnt <= 0;
         strobes.delete();
      end else begin
         if (dout_valid) strobes.push_back(strobe_t'{e_cnt + 1, dout_in});
         e_cnt <= e_cnt + 1;
      end
   end

   // Word on screen: the newest strobe strictly before the latest vblank transfer the outputs have seen.
   function automatic logic [15:0] disp_word(int k);
      int j, lim;
      logic [15:0] w;
      w = 16'h0;
      if (k - 1 < TP) return 16'h0;
      j   = ((k - 1 - TP) / FRAME) * FRAME + TP;
      lim = j * CD;
      foreach (strobes[i]) if (strobes[i].e < lim) w = strobes[i].w;
      return w;
   endfunction

   // Expected outputs after edge e: they show raster pixel k-1, where k pixel slots have elapsed.
   function automatic logic [8:0] model(int e);
      int k, p, h, v;
      logic hs, vs, fs;
      logic [5:0] c;
      logic [15:0] w;
      k = e / CD;
      if (k == 0) return RESET_VEC;
      p  = (k - 1) % FRAME;
      h  = p % HT;
      v  = p / HT;
      hs = !(h >= HS0 && h < HS1);
      vs = !(v >= VS0 && v < VS1);
      c  = 6'b0;
      if (h < HA && v < VA) begin
         w = disp_word(k);
         c = w[15 - h / (HA / 16)] ? FG : BG;
`ifdef VGA_WORD_DISPLAY_GRID_EN
         if (h % (HA / 16) == 0 || v == 0 || v == VA - 1) c = 6'b111111;
`endif
      end
      fs = (e % CD == 0) && (k % FRAME == 0);
      return {hs, vs, c, fs};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, e_cnt, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (mon_en) check_output("stream", {23'b0, dut_vec}, {23'b0, model(e_cnt)});
   end

   task automatic wait_frame_start();
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (frame_start !== 1'b1 && n < 2 * FRAME * CD);
      if (frame_start !== 1'b1) check_output("frame_start_timeout", 0, 1);
   endtask

   task automatic wait_pixel(input int h, input int v);
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!(e_cnt >= CD && ((e_cnt / CD - 1) % FRAME) == v * HT + h) && n < FRAME * CD + 4);
      if (!(e_cnt >= CD && ((e_cnt / CD - 1) % FRAME) == v * HT + h)) check_output("pixel_timeout", 0, 1);
   endtask

   task automatic apply_strobe(input logic [15:0] w);
      dout_in    = w;
      dout_valid = 1'b1;
      @(negedge clk_in);
      dout_valid = 1'b0;
      dout_in    = 16'($urandom);
   endtask

   task automatic check_first_hsync();
      int n = 0;
      while (h_sync !== 1'b0 && n < 4 * HT * CD) begin
         @(negedge clk_in);
         n++;
      end
      check_output("first_hsync_edge", e_cnt, CD * (HS0 + 1));
   endtask

   initial begin
      int n, t0, k0, e_t;
      tbl[0]  = '{16'h8001,  0, 1, FG};
      tbl[1]  = '{16'h8001,  3, 2, BG};
      tbl[2]  = '{16'h8001, 31, 5, FG};
      tbl[3]  = '{16'h8001, 30, 0, FG};
      tbl[4]  = '{16'h8001, 34, 2, 6'b0};
      tbl[5]  = '{16'h8001,  5, 7, 6'b0};
      tbl[6]  = '{16'hAAAA,  2, 0, BG};
      tbl[7]  = '{16'hAAAA,  4, 4, FG};
      tbl[8]  = '{16'h0000, 16, 3, BG};
      tbl[9]  = '{16'hFFFF, 17, 5, FG};
      tbl[10] = '{16'h1234, 24, 1, BG};

      #1 rst_in = 1'b0;
      #1 mon_en = 1'b1;
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      check_output("reset_idle", dut_vec, RESET_VEC);

      check_first_hsync();
      t0 = e_cnt;
      n = 0;
      while (h_sync === 1'b0 && n < 100) begin
         @(negedge clk_in);
         n++;
      end
      check_output("hsync_width", n, CD * HSW);
      n = 0;
      while (h_sync !== 1'b0 && n < 4 * HT * CD) begin
         @(negedge clk_in);
         n++;
      end
      check_output("hsync_period", e_cnt - t0, CD * HT);

      n = 0;
      while (v_sync !== 1'b0 && n < 2 * FRAME * CD) begin
         @(negedge clk_in);
         n++;
      end
      n = 0;
      while (v_sync === 1'b0 && n < 2000) begin
         @(negedge clk_in);
         n++;
      end
      check_output("vsync_width", n, CD * HT * VSW);

      n = 0;
      for (int i = 0; i < 3 * FRAME * CD; i++) begin
         @(negedge clk_in);
         if (frame_start === 1'b1) n++;
      end
      check_output("frame_start_count", n, 3);

      // Word strobed mid-frame must not appear until the following frame.
      wait_frame_start();
      apply_strobe(16'h8001);
      wait_pixel(1, 3);
      check_output("current_frame_hold", color, BG);
      wait_frame_start();
      wait_pixel(1, 1);
      check_output("next_frame_shows", color, FG);

`ifndef VGA_WORD_DISPLAY_GRID_EN
      for (int i = 0; i < 11; i++) begin
         wait_frame_start();
         apply_strobe(tbl[i].word);
         wait_frame_start();
         wait_pixel(tbl[i].h, tbl[i].v);
         check_output($sformatf("table_%0d", i), color, tbl[i].exp);
      end
`endif

      // Last write in a frame wins.
      wait_frame_start();
      apply_strobe(16'hFFFF);
      apply_strobe(16'h0000);
      wait_frame_start();
      wait_pixel(1, 1);
      check_output("last_wins_left", color, BG);
      wait_pixel(31, 4);
      check_output("last_wins_right", color, BG);

      // Strobe exactly on the transfer edge while another word is pending.
      wait_frame_start();
      apply_strobe(16'h00FF);
      k0  = e_cnt / CD;
      e_t = ((k0 / FRAME) * FRAME + TP) * CD;
      n = 0;
      while (e_cnt != e_t - 1 && n < 2 * FRAME * CD) begin
         @(negedge clk_in);
         n++;
      end
      if (e_cnt != e_t - 1) check_output("xfer_edge_timeout", e_cnt, e_t - 1);
      apply_strobe(16'hAAAA);
      wait_frame_start();
      wait_pixel(1, 1);
      check_output("coincide_old_left", color, BG);
      wait_pixel(31, 2);
      check_output("coincide_old_right", color, FG);
      wait_frame_start();
      wait_pixel(1, 1);
      check_output("coincide_new_left", color, FG);
      wait_pixel(31, 2);
      check_output("coincide_new_right", color, BG);

      for (int i = 0; i < 4 * FRAME * CD; i++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 59) == 0) begin
            dout_in    = 16'($urandom);
            dout_valid = 1'b1;
         end else begin
            dout_valid = 1'b0;
         end
      end
      @(negedge clk_in);
      dout_valid = 1'b0;

      // Reset mid-frame takes effect between clock edges.
      wait_frame_start();
      wait_pixel(16, 3);
      #2 rst_in = 1'b0;
      #1 check_output("reset_async", dut_vec, RESET_VEC);
      repeat (3) @(negedge clk_in);
      rst_in = 1'b1;
      check_first_hsync();
      wait_frame_start();
      wait_pixel(1, 1);
      check_output("post_reset_left", color, BG);
      wait_pixel(31, 4);
      check_output("post_reset_right", color, BG);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_word_display.md
Name: vga_word_display

Overview:
- Downstream display stage of mytop: takes the CPU's 16-bit dout word and shows it on a 640x480@60 Hz VGA monitor as 16 vertical bars.
- Each bar is 40 px wide. Bit 15 is the leftmost bar, bit 0 the rightmost.
- A set bit draws the bar in the foreground colour; a clear bit draws it in the background colour.
- New words are double-buffered and only take effect at the start of vertical blanking, so the display never tears.

Parameters:
- CLK_DIV, 2: clk_in cycles per pixel (50 MHz clk_in -> 25 MHz pixel rate); minimum 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- FG_COLOR, 6'b001100: {red1,red0,green1,green0,blue1,blue0} for a set bit.
- BG_COLOR, 6'b000001: colour for a clear bit.

Ports:
- clk_in, input, 1: single system clock.
- rst_in, input, 1: asynchronous, active-low reset.
- dout_in, input, 16: CPU output word.
- dout_valid, input, 1: one-cycle strobe; capture dout_in.
- h_sync, output, 1: horizontal sync, active low.
- v_sync, output, 1: vertical sync, active low.
- red0, red1, green0, green1, blue0, blue1, output, 1 each: 2-bit colour channels.
- frame_start, output, 1: one-clk_in pulse at the start of each frame.

Behaviour:
Reset (rst_in=0, asynchronous):
- Pixel divider, h_cnt and v_cnt are cleared to 0.
- pend_reg, pend_flag and disp_reg are cleared to 0.
- h_sync=1, v_sync=1, all colour outputs 0, frame_start=0.

Pixel enable:
- A mod-CLK_DIV counter raises pix_en for 1 clk_in cycle every CLK_DIV cycles.
- The first pix_en occurs CLK_DIV cycles after reset release.

Counters (advance only on pix_en):
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800), then wraps to 0.
- v_cnt increments when h_cnt wraps. It runs 0..V_TOTAL-1 (525), then wraps to 0.

Outputs:
- All outputs are registered and update only on pix_en cycles.
- They are computed from the counter values present before that pix_en's increment, giving a fixed latency of 1 pixel slot (CLK_DIV clk_in) relative to the counters.
- h_sync=0 while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- v_sync=0 while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- In the active area (h_cnt < H_ACTIVE and v_cnt < V_ACTIVE):
  - bar index b = h_cnt / (H_ACTIVE/16).
  - Colour = disp_reg[15-b] ? FG_COLOR : BG_COLOR.
- Outside the active area all colour outputs are 0.
- frame_start=1 for exactly one clk_in cycle, on the pix_en at which the counters wrap to (0,0).

Capture and transfer:
- dout_valid=1 -> pend_reg <= dout_in and pend_flag <= 1. Last write wins; multiple writes in one frame keep only the final one.
- Transfer happens on the pix_en where the counters become (h=0, v=V_ACTIVE), i.e. start of vertical blanking. If pend_flag=1 at that edge: disp_reg <= pend_reg, pend_flag <= 0.
- If dout_valid coincides with the transfer edge:
  - Transfer uses the old pend_reg.
  - The new word lands in pend_reg and pend_flag stays 1.
  - The new word is displayed one frame later.
- If there is no pending word at the transfer edge, disp_reg holds its value.
- Reset mid-frame aborts the frame immediately. Timing restarts at (0,0) with the display all-background.

Optional Feature:
- Macro: VGA_WORD_DISPLAY_GRID_EN.
- Defined:
  - Active pixels with h_cnt % (H_ACTIVE/16) == 0 are forced to white (6'b111111), regardless of bit value.
  - Pixels on active line v_cnt==0 or v_cnt==V_ACTIVE-1 are also forced to white.
- Undefined: no grid; bar colours only. Logic and ports are otherwise identical.

Test Plan:
- Reset then free-run: h_sync low pulse = 96 px = 192 clk_in, period 1600 clk_in; v_sync low = 2 lines = 3200 clk_in, period 525 lines (840000 clk_in); frame_start exactly once per frame.
- dout_in=16'h8001 strobed at line 100 -> current frame still shows 0 (all BG). From the next frame onward: pixels 0..39 and 600..639 = 6'b001100 (FG), all other active pixels = 6'b000001 (BG).
- Strobe 16'hFFFF then 16'h0000 within one frame -> next frame entirely BG.
- Strobe 16'hAAAA exactly on the transfer edge (h=0, v=480) while 16'h00FF is pending -> next frame shows 00FF; the following frame shows AAAA.
- Assert rst_in=0 at line 300 pixel 320 -> all outputs immediately take reset values; after release, first h_sync low starts 656 px later.
- With VGA_WORD_DISPLAY_GRID_EN and disp_reg=0 -> pixels 0, 40, ..., 600 on every active line, and all of lines 0 and 479, are 6'b111111.
